// File: rtl/dot_product_sequencer.sv
// Dot-product sequencer: feeds one activation at a time into the single-weight inference pipeline and accumulates the results.
// Latency: per element 1 ISSUE cycle + pipeline latency; done pulses one cycle after the DONE state (2 cycles after op_start for len=0).
// Backpressure: one element outstanding at a time; op_start and buffer writes are ignored while busy.
// Optional macro DPS_TIMEOUT_EN: per-element watchdog that aborts the op and raises timeout_err.
module dot_product_sequencer #(
  parameter int VEC_LEN        = 16,
  parameter int ADDR_WIDTH     = 4,
  parameter int ACC_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  act_wr_en,
  input  logic [ADDR_WIDTH-1:0] act_wr_idx,
  input  logic [7:0]            act_wr_data,
  input  logic                  op_start,
  input  logic [ADDR_WIDTH:0]   op_len,
  input  logic [ADDR_WIDTH-1:0] op_base_addr,
  output logic                  core_start,
  output logic [ADDR_WIDTH-1:0] core_weight_addr,
  output logic [7:0]            core_activation,
  input  logic                  core_valid,
  input  logic [63:0]           core_result,
  input  logic                  core_zero_skipped,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_WIDTH-1:0]  acc_out,
  output logic [ADDR_WIDTH:0]   zero_count,
  output logic                  overflow,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [ADDR_WIDTH:0] VEC_LEN_W = (ADDR_WIDTH+1)'(VEC_LEN);

  // Reject configurations whose index width cannot cover the buffer.
  if (((1 << ADDR_WIDTH) < VEC_LEN) || (ACC_WIDTH > 64) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("dot_product_sequencer: illegal parameter combination");
  end

  state_t                state_q, state_d;
  logic [7:0]            buf_q [VEC_LEN];
  logic [ADDR_WIDTH:0]   len_q, i_q, i_next, len_clamped, elem_idx;
  logic [ADDR_WIDTH-1:0] base_q, addr_q, addr_d;
  logic [7:0]            act_q, act_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [ACC_WIDTH:0]    sum_w;
  logic [ADDR_WIDTH:0]   zcnt_q, zcnt_d;
  logic                  ovf_q, sat_hit, res_hi_nz;
  logic                  busy_q, done_q, cstart_q;
  logic                  accept, elem_done, last_elem, wd_expire;

  assign len_clamped = (op_len > VEC_LEN_W) ? VEC_LEN_W : op_len;
  assign i_next      = i_q + 1'b1;
  assign last_elem   = (i_next == len_q);

  // Result bits above the accumulator width force saturation.
  if (ACC_WIDTH < 64) begin : g_hi
    assign res_hi_nz = |core_result[63:ACC_WIDTH];
  end else begin : g_nohi
    assign res_hi_nz = 1'b0;
  end

`ifdef DPS_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            tmo_q;

  assign wd_expire = (state_q == S_WAIT) && !core_valid && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts WAIT cycles, zero whenever outside WAIT so it restarts on each entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      tmo_q <= 1'b0;
    end else begin
      wd_q <= (state_q == S_WAIT) ? wd_q + 1'b1 : '0;
      if (accept)         tmo_q <= 1'b0;
      else if (wd_expire) tmo_q <= 1'b1;
    end
  end

  assign timeout_err = tmo_q;
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (op_start) state_d = (len_clamped == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (core_valid)     state_d = last_elem ? S_DONE : S_ISSUE;
        else if (wd_expire) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath decode: element fetch and saturating accumulate.
  always_comb begin
    accept    = (state_q == S_IDLE) && op_start;
    elem_done = (state_q == S_WAIT) && core_valid;
    elem_idx  = accept ? '0 : i_next;
    addr_d    = (accept ? op_base_addr : base_q) + elem_idx[ADDR_WIDTH-1:0];
    act_d     = buf_q[elem_idx[ADDR_WIDTH-1:0]];
    sum_w     = {1'b0, acc_q} + {1'b0, core_result[ACC_WIDTH-1:0]};
    sat_hit   = res_hi_nz || sum_w[ACC_WIDTH];
    acc_d     = sat_hit ? '1 : sum_w[ACC_WIDTH-1:0];
    zcnt_d    = zcnt_q + {{ADDR_WIDTH{1'b0}}, core_zero_skipped};
  end

  // Activation buffer: written only while idle, out-of-range indices dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < VEC_LEN; k++) buf_q[k] <= '0;
    end else if ((state_q == S_IDLE) && act_wr_en && ({1'b0, act_wr_idx} < VEC_LEN_W)) begin
      buf_q[act_wr_idx] <= act_wr_data;
    end
  end

  // Op control: latch command, track element index, registered pipeline handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= '0;
      base_q   <= '0;
      i_q      <= '0;
      addr_q   <= '0;
      act_q    <= '0;
      cstart_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cstart_q <= (state_d == S_ISSUE);
      done_q   <= (state_q == S_DONE);
      if (accept) begin
        len_q  <= len_clamped;
        base_q <= op_base_addr;
        i_q    <= '0;
        busy_q <= 1'b1;
      end else if (state_q == S_DONE) begin
        busy_q <= 1'b0;
      end
      if (elem_done) i_q <= i_next;
      // Address and activation stay put between issues.
      if (state_d == S_ISSUE) begin
        addr_q <= addr_d;
        act_q  <= act_d;
      end
    end
  end

  // Accumulator, zero-skip counter and sticky overflow; cleared per accepted op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      zcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      acc_q  <= '0;
      zcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else if (elem_done) begin
      acc_q  <= acc_d;
      zcnt_q <= zcnt_d;
      if (sat_hit) ovf_q <= 1'b1;
    end
  end

  assign core_start       = cstart_q;
  assign core_weight_addr = addr_q;
  assign core_activation  = act_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign acc_out          = acc_q;
  assign zero_count       = zcnt_q;
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
module tb_dot_product_sequencer;
  localparam int AW = 4;
  localparam int VL = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          act_wr_en;
  logic [AW-1:0] act_wr_idx;
  logic [7:0]    act_wr_data;
  logic          op_start;
  logic [AW:0]   op_len;
  logic [AW-1:0] op_base_addr;
  logic          core_start;
  logic [AW-1:0] core_weight_addr;
  logic [7:0]    core_activation;
  logic          core_valid;
  logic [63:0]   core_result;
  logic          core_zero_skipped;
  logic          busy, done, overflow, timeout_err;
  logic [31:0]   acc_out;
  logic [AW:0]   zero_count;

  always #5 clk = ~clk;

  dot_product_sequencer dut (
    .clk(clk), .rst(rst),
    .act_wr_en(act_wr_en), .act_wr_idx(act_wr_idx), .act_wr_data(act_wr_data),
    .op_start(op_start), .op_len(op_len), .op_base_addr(op_base_addr),
    .core_start(core_start), .core_weight_addr(core_weight_addr), .core_activation(core_activation),
    .core_valid(core_valid), .core_result(core_result), .core_zero_skipped(core_zero_skipped),
    .busy(busy), .done(done), .acc_out(acc_out), .zero_count(zero_count),
    .overflow(overflow), .timeout_err(timeout_err)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] buf_m [VL];

  typedef struct {
    logic [4:0]       len;
    logic [3:0]       base;
    int               lat;
    logic [3:0][63:0] res;
    logic [3:0]       zs;
    bit               inj;
    logic [31:0]      exp_acc;
    logic [4:0]       exp_zc;
    logic             exp_ovf;
    int               exp_starts;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] idx, input logic [7:0] data);
    @(negedge clk);
    act_wr_en = 1'b1; act_wr_idx = idx; act_wr_data = data;
    @(negedge clk);
    act_wr_en = 1'b0;
    buf_m[idx] = data;
  endtask

  // Drives one op and plays the pipeline: result k returned lat cycles after start k.
  task automatic run_op(input logic [4:0] len, input logic [3:0] base, input int lat,
                        input logic [3:0][63:0] res, input logic [3:0] zs, input bit inj,
                        input int budget, output int done_cyc, output int nst);
    int pend;
    int k;
    logic [3:0] ea;
    @(negedge clk);
    op_start = 1'b1; op_len = len; op_base_addr = base;
    @(negedge clk);
    op_start = 1'b0;
    pend = -1; k = 0; nst = 0; done_cyc = -1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      core_valid = 1'b0; act_wr_en = 1'b0; op_start = 1'b0;
      if (cyc == 1) chk("busy_after_start", busy, 1);
      if (done) begin done_cyc = cyc; break; end
      if (pend == 0) begin
        core_valid = 1'b1; core_result = res[k%4]; core_zero_skipped = zs[k%4];
        k++; pend = -1;
      end else if (pend > 0) begin
        pend--;
      end
      if (core_start) begin
        if (nst < VL) begin
          ea = base + 4'(nst);
          chk($sformatf("addr[%0d]", nst), core_weight_addr, ea);
          chk($sformatf("act[%0d]", nst), core_activation, buf_m[nst]);
        end else begin
          chk("too_many_starts", 1, 0);
        end
        nst++;
        pend = lat - 1;
      end
      if (inj && cyc == 3) begin
        op_start = 1'b1; op_len = 5'd1; op_base_addr = 4'd9;
        act_wr_en = 1'b1; act_wr_idx = 4'd0; act_wr_data = 8'hAA;
      end
      @(negedge clk);
    end
    core_valid = 1'b0; op_start = 1'b0; act_wr_en = 1'b0;
    if (done_cyc < 0) chk("done_within_budget", 0, 1);
  endtask

  initial begin
    int dc, ns, clen, found;
    vecs[0] = '{5'd4, 4'd0, 1, {64'd20, 64'd0, 64'd12, 64'd6}, 4'b0100, 1'b0, 32'd38, 5'd1, 1'b0, 4};
    vecs[1] = '{5'd4, 4'd14, 3, {64'd4, 64'd3, 64'd2, 64'd1}, 4'b0000, 1'b0, 32'd10, 5'd0, 1'b0, 4};
    vecs[2] = '{5'd0, 4'd5, 1, {64'd1, 64'd1, 64'd1, 64'd1}, 4'b0000, 1'b0, 32'd0, 5'd0, 1'b0, 0};
    vecs[3] = '{5'd2, 4'd0, 2, {64'd0, 64'd0, 64'h20, 64'hFFFF_FFF0}, 4'b0000, 1'b0, 32'hFFFF_FFFF, 5'd0, 1'b1, 2};
    vecs[4] = '{5'd1, 4'd3, 1, {64'd0, 64'd0, 64'd0, 64'd7}, 4'b0000, 1'b0, 32'd7, 5'd0, 1'b0, 1};
    vecs[5] = '{5'd1, 4'd0, 1, {64'd0, 64'd0, 64'd0, 64'h1_0000_0000}, 4'b0000, 1'b0, 32'hFFFF_FFFF, 5'd0, 1'b1, 1};
    vecs[6] = '{5'd2, 4'd6, 5, {64'd0, 64'd0, 64'd1, 64'd1}, 4'b0011, 1'b1, 32'd2, 5'd2, 1'b0, 2};
    vecs[7] = '{5'd1, 4'd0, 1, {64'd0, 64'd0, 64'd0, 64'd0}, 4'b0001, 1'b0, 32'd0, 5'd1, 1'b0, 1};
    vecs[8] = '{5'd20, 4'd8, 1, {64'd1, 64'd1, 64'd1, 64'd1}, 4'b1111, 1'b0, 32'd16, 5'd16, 1'b0, 16};

    for (int i = 0; i < VL; i++) buf_m[i] = 8'd0;
    rst = 1'b1; act_wr_en = 1'b0; act_wr_idx = '0; act_wr_data = '0;
    op_start = 1'b0; op_len = '0; op_base_addr = '0;
    core_valid = 1'b0; core_result = '0; core_zero_skipped = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_acc", acc_out, 0);
    chk("rst_zero_count", zero_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_timeout", timeout_err, 0);
    rst = 1'b0;

    wr(4'd0, 8'd2); wr(4'd1, 8'd3); wr(4'd2, 8'd0); wr(4'd3, 8'd5);

    for (int v = 0; v < 9; v++) begin
      clen = (vecs[v].len > 5'd16) ? 16 : int'(vecs[v].len);
      run_op(vecs[v].len, vecs[v].base, vecs[v].lat, vecs[v].res, vecs[v].zs, vecs[v].inj,
             clen * (vecs[v].lat + 2) + 10, dc, ns);
      chk($sformatf("v%0d_acc", v), acc_out, vecs[v].exp_acc);
      chk($sformatf("v%0d_zero_count", v), zero_count, vecs[v].exp_zc);
      chk($sformatf("v%0d_overflow", v), overflow, vecs[v].exp_ovf);
      chk($sformatf("v%0d_timeout", v), timeout_err, 0);
      chk($sformatf("v%0d_starts", v), ns, vecs[v].exp_starts);
      chk($sformatf("v%0d_latency_bound", v), (dc > 0) && (dc <= clen * (vecs[v].lat + 2) + 2), 1);
      if (clen == 0) chk($sformatf("v%0d_len0_done_cycle", v), dc, 2);
      @(negedge clk);
      chk($sformatf("v%0d_done_one_cycle", v), done, 0);
      chk($sformatf("v%0d_busy_clear", v), busy, 0);
    end

    // Reset in the middle of the second element's WAIT.
    @(negedge clk);
    op_start = 1'b1; op_len = 5'd4; op_base_addr = 4'd0;
    @(negedge clk);
    op_start = 1'b0;
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      if (core_start) found = 1;
      else @(negedge clk);
    end
    chk("rstseq_first_start", found, 1);
    @(negedge clk);
    core_valid = 1'b1; core_result = 64'd5; core_zero_skipped = 1'b0;
    @(negedge clk);
    core_valid = 1'b0;
    @(negedge clk);
    chk("rstseq_acc_before", acc_out, 5);
    chk("rstseq_addr_before", core_weight_addr, 1);
    rst = 1'b1;
    #1;
    chk("rstseq_busy", busy, 0);
    chk("rstseq_core_start", core_start, 0);
    chk("rstseq_acc", acc_out, 0);
    chk("rstseq_addr", core_weight_addr, 0);
    chk("rstseq_act", core_activation, 0);
    chk("rstseq_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < VL; i++) buf_m[i] = 8'd0;
    run_op(5'd1, 4'd0, 1, {64'd0, 64'd0, 64'd0, 64'd9}, 4'b0000, 1'b0, 20, dc, ns);
    chk("postrst_acc", acc_out, 9);
    chk("postrst_starts", ns, 1);

`ifdef DPS_TIMEOUT_EN
    // No result ever returns: watchdog aborts after 32 WAIT cycles.
    run_op(5'd2, 4'd0, 100000, {64'd0, 64'd0, 64'd0, 64'd0}, 4'b0000, 1'b0, 60, dc, ns);
    chk("tmo_flag", timeout_err, 1);
    chk("tmo_done_cycle", dc, 35);
    chk("tmo_starts", ns, 1);
    chk("tmo_acc", acc_out, 0);
    run_op(5'd1, 4'd0, 1, {64'd0, 64'd0, 64'd0, 64'd3}, 4'b0000, 1'b0, 20, dc, ns);
    chk("tmo_cleared", timeout_err, 0);
    chk("tmo_next_acc", acc_out, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
